// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority,
// PC redirect, DMEM timeout watchdog and saturating perf counters.
module pipeline_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_hazard,
    input  logic                  mispredict,
    input  logic [DATA_WIDTH-1:0] target_ex,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    input  logic                  halt_wb,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_memwb,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_BUBBLE,
        DMEM_WAIT,
        HALT
    } state_e;

    localparam int WCW = $clog2(DMEM_TIMEOUT) + 1;
    localparam logic [WCW-1:0] TO_M1 = WCW'(DMEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [WCW-1:0]       wait_q, wait_d;
    logic                 tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] sc_q, fc_q;
    logic                 sc_inc, fc_inc;
    logic                 hz;

    always_comb begin
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        flush_memwb    = 1'b0;
        redirect_valid = 1'b0;
        fc_inc         = 1'b0;
        hz             = 1'b0;
        state_d        = state_q;
        wait_d         = wait_q;
        tmo_d          = tmo_q;
        if (reset) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_memwb = 1'b1;
        end else if (state_q == HALT) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (halt_wb) begin
            state_d = HALT;
            wait_d  = '0;
        end else if (dmem_busy) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            stall_mem   = 1'b1;
            flush_memwb = 1'b1;
            wait_d      = wait_q + WCW'(1);
            if (wait_q >= TO_M1) begin
                state_d = HALT;
                tmo_d   = 1'b1;
            end else begin
                state_d = DMEM_WAIT;
            end
        end else begin
            wait_d  = '0;
            state_d = RUN;
            if (mispredict) begin
                redirect_valid = 1'b1;
                flush_ifid     = 1'b1;
                flush_idex     = 1'b1;
                fc_inc         = 1'b1;
            end else begin
                // The bubble cycle masks the still-asserted hazard once.
                hz         = mem_hazard && (state_q != LOAD_BUBBLE);
                stall_if   = hz || !imem_ready;
                stall_id   = hz;
                flush_idex = hz;
                flush_ifid = !imem_ready && !hz;
                if (hz) begin
                    state_d = LOAD_BUBBLE;
                end
            end
        end
    end

    assign sc_inc       = stall_if && !reset && (state_q != HALT);
    assign redirect_pc  = target_ex;
    assign halted       = (state_q == HALT);
    assign timeout_err  = tmo_q;
    assign stall_cycles = sc_q;
    assign flush_count  = fc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
            sc_q    <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            if (sc_inc && (sc_q != '1)) begin
                sc_q <= sc_q + CNT_WIDTH'(1);
            end
            if (fc_inc && (fc_q != '1)) begin
                fc_q <= fc_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule
